// File: rtl/ddr_pkg.sv
// Shared arrow codes, judge state encoding and BCD limits for the DDR game blocks.
package ddr_pkg;
  localparam logic [2:0] ARROW_LEFT  = 3'd0;
  localparam logic [2:0] ARROW_DOWN  = 3'd1;
  localparam logic [2:0] ARROW_UP    = 3'd2;
  localparam logic [2:0] ARROW_RIGHT = 3'd3;
  localparam logic [2:0] ARROW_BLANK = 3'b100;

  typedef enum logic [2:0] {IDLE, ARMED, WINDOW, WAIT, OVER} judge_state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;
endpackage

// File: rtl/bcd_sat_add4.sv
// Four-digit BCD add of a small increment (1 or 2), clamped at 9999 on carry-out.
module bcd_sat_add4
  import ddr_pkg::*;
(
  input  logic [15:0] a,
  input  logic [1:0]  inc,
  output logic [15:0] sum
);
  logic [15:0] raw;
  logic [4:0]  d;
  logic [1:0]  c;

  always_comb begin
    raw = '0;
    d   = '0;
    c   = inc;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {3'b0, c};
      if (d > 5'd9) begin
        raw[i*4 +: 4] = 4'(d - 5'd10);
        c = 2'd1;
      end else begin
        raw[i*4 +: 4] = d[3:0];
        c = 2'd0;
      end
    end
    sum = (c != 2'd0) ? BCD_MAX : raw;
  end
endmodule

// File: rtl/ddr_judge.sv
// Judges debounced button presses against the hit-slot arrow each beat.
// Optional score bonus for long combos: DDR_JUDGE_COMBO_BONUS_EN.
module ddr_judge
  import ddr_pkg::*;
#(
  parameter int MAX_MISSES = 3,
  parameter int COMBO_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               beat_tick,
  input  logic [2:0]         hit_arrow,
  input  logic [3:0]         btn,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [15:0]        score_bcd,
  output logic [COMBO_W-1:0] combo,
  output logic [3:0]         misses,
  output logic               playing,
  output logic               game_over
);
  judge_state_t state;
  logic [3:0]  btn_q;
  logic [2:0]  target;
  logic [3:0]  btn_edge, misses_nx;
  logic        any_edge, single, judge, timeout, hit_now, miss_now, over_now;
  logic [1:0]  inc;
  logic [15:0] score_nx;

  assign btn_edge  = btn & ~btn_q;
  assign any_edge  = |btn_edge;
  assign single    = any_edge && ((btn_edge & (btn_edge - 4'd1)) == 4'd0);
  assign judge     = (state == WINDOW) && any_edge;
  assign timeout   = (state == WINDOW) && beat_tick && !any_edge && !target[2];
  assign hit_now   = judge && single && !target[2] && btn_edge[target[1:0]];
  assign miss_now  = (judge && !hit_now) || timeout;
  assign misses_nx = misses + 4'd1;
  assign over_now  = miss_now && (misses_nx >= 4'(MAX_MISSES));

`ifdef DDR_JUDGE_COMBO_BONUS_EN
  assign inc = (combo >= COMBO_W'(10)) ? 2'd2 : 2'd1;
`else
  assign inc = 2'd1;
`endif

  bcd_sat_add4 u_add (.a(score_bcd), .inc(inc), .sum(score_nx));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      btn_q      <= '0;
      target     <= ARROW_BLANK;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score_bcd  <= '0;
      combo      <= '0;
      misses     <= '0;
      playing    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      btn_q      <= btn;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (start) begin
        state     <= ARMED;
        score_bcd <= '0;
        combo     <= '0;
        misses    <= '0;
        playing   <= 1'b1;
        game_over <= 1'b0;
      end else begin
        if (hit_now) begin
          hit_pulse <= 1'b1;
          score_bcd <= score_nx;
          combo     <= (&combo) ? combo : combo + COMBO_W'(1);
        end
        if (miss_now) begin
          miss_pulse <= 1'b1;
          combo      <= '0;
          misses     <= misses_nx;
        end
        case (state)
          ARMED: if (beat_tick) begin
            state  <= WINDOW;
            target <= hit_arrow;
          end
          WINDOW, WAIT: begin
            // A late press coincident with the beat still counts against the old target.
            if (over_now) begin
              state     <= OVER;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end else if (beat_tick) begin
              state  <= WINDOW;
              target <= hit_arrow;
            end else if (judge) begin
              state <= WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ddr_judge.sv
// Directed plus randomized checks of ddr_judge against an integer-score reference model.
module tb_ddr_judge;
  localparam int MAXM = 3;
  localparam int CW   = 8;
`ifdef DDR_JUDGE_COMBO_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif
  localparam int S_IDLE = 0, S_ARMED = 1, S_WINDOW = 2, S_WAIT = 3, S_OVER = 4;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, beat_tick = 1'b0;
  logic [2:0]    hit_arrow = 3'b100;
  logic [3:0]    btn = 4'b0;
  logic          hit_pulse, miss_pulse, playing, game_over;
  logic [15:0]   score_bcd;
  logic [CW-1:0] combo;
  logic [3:0]    misses;

  ddr_judge #(.MAX_MISSES(MAXM), .COMBO_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .beat_tick(beat_tick),
    .hit_arrow(hit_arrow), .btn(btn), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .score_bcd(score_bcd), .combo(combo),
    .misses(misses), .playing(playing), .game_over(game_over));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_state, m_target, m_score, m_combo, m_misses;
  bit [3:0] m_prev;
  bit m_hit, m_miss;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int arrow_of(logic [2:0] a);
    return a[2] ? -1 : int'(a[1:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_target = -1; m_prev = '0;
    m_score = 0; m_combo = 0; m_misses = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_step();
    bit [3:0] e;
    e = btn & ~m_prev;
    m_prev = btn;
    m_hit = 0; m_miss = 0;
    if (start) begin
      m_score = 0; m_combo = 0; m_misses = 0; m_state = S_ARMED;
      return;
    end
    case (m_state)
      S_ARMED: if (beat_tick) begin
        m_state = S_WINDOW; m_target = arrow_of(hit_arrow);
      end
      S_WINDOW: begin
        if (e != 0) begin
          m_hit  = ($countones(e) == 1) && (m_target >= 0) && (e == 4'(1 << m_target));
          m_miss = !m_hit;
        end else if (beat_tick && m_target >= 0) begin
          m_miss = 1;
        end
        if (m_hit) begin
          m_score += (BONUS && m_combo >= 10) ? 2 : 1;
          if (m_score > 9999) m_score = 9999;
          if (m_combo < 255) m_combo++;
        end
        if (m_miss) begin
          m_combo = 0;
          m_misses++;
          if (m_misses >= MAXM) begin
            m_state = S_OVER;
            return;
          end
        end
        if (beat_tick) m_target = arrow_of(hit_arrow);
        else if (e != 0) m_state = S_WAIT;
      end
      S_WAIT: if (beat_tick) begin
        m_target = arrow_of(hit_arrow); m_state = S_WINDOW;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hit"},  hit_pulse,  m_hit);
    chk({tag, ".miss"}, miss_pulse, m_miss);
    chk({tag, ".score"}, score_bcd, to_bcd(m_score));
    chk({tag, ".combo"}, combo, m_combo);
    chk({tag, ".misses"}, misses, m_misses);
    chk({tag, ".playing"}, playing, (m_state >= S_ARMED && m_state <= S_WAIT));
    chk({tag, ".over"}, game_over, (m_state == S_OVER));
  endtask

  task automatic cyc(input bit s, input bit b, input logic [2:0] a, input logic [3:0] bt,
                     input string tag);
    start = s; beat_tick = b; hit_arrow = a; btn = bt;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    start = 0; beat_tick = 0;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1; rst = 1;

    // Async reset mid-game, no clock edge in between
    cyc(1, 0, 3'd4, 4'b0000, "start0");
    cyc(0, 1, 3'd2, 4'b0000, "arm0");
    chk("mid.playing", playing, 1'b1);
    #2; rst = 0; model_reset();
    #1; check_all("async_rst");
    chk("async_rst.playing0", playing, 1'b0);
    @(posedge clk); #1; rst = 1;

    cyc(1, 0, 3'd4, 4'b0000, "start1");
    cyc(0, 1, 3'd2, 4'b0000, "arm1");
    cyc(0, 0, 3'd2, 4'b0100, "hit1");
    chk("hit1.pulse", hit_pulse, 1'b1);
    chk("hit1.score", score_bcd, 16'h0001);
    chk("hit1.combo", combo, 8'd1);

    cyc(0, 1, 3'd1, 4'b0100, "beat_t1");
    cyc(0, 0, 3'd1, 4'b1100, "wrong");
    chk("wrong.miss", miss_pulse, 1'b1);
    chk("wrong.combo", combo, 8'd0);
    chk("wrong.misses", misses, 4'd1);
    cyc(0, 0, 3'd1, 4'b0100, "release");
    cyc(0, 0, 3'd1, 4'b0110, "second");
    chk("second.nopulse", {hit_pulse, miss_pulse}, 2'b00);

    cyc(0, 1, 3'd0, 4'b0000, "beat_t0");
    cyc(0, 0, 3'd0, 4'b0000, "wait_t0");
    cyc(0, 1, 3'd4, 4'b0000, "timeout");
    chk("timeout.miss", miss_pulse, 1'b1);
    chk("timeout.misses", misses, 4'd2);
    cyc(0, 0, 3'd4, 4'b0000, "blank_wait");
    cyc(0, 1, 3'd0, 4'b0000, "blank_beat");
    chk("blank.nopulse", {hit_pulse, miss_pulse}, 2'b00);

    cyc(0, 1, 3'd3, 4'b0001, "coinc");
    chk("coinc.hit", {hit_pulse, miss_pulse}, 2'b10);
    cyc(0, 0, 3'd3, 4'b1001, "open3");
    chk("open3.hit", hit_pulse, 1'b1);
    chk("open3.score", score_bcd, 16'h0003);
    chk("open3.combo", combo, 8'd2);

    // Three misses end the game
    cyc(1, 0, 3'd1, 4'b0000, "restart");
    cyc(0, 1, 3'd1, 4'b0000, "g_b1");
    cyc(0, 0, 3'd1, 4'b0100, "g_m1");
    cyc(0, 1, 3'd1, 4'b0000, "g_b2");
    cyc(0, 0, 3'd1, 4'b0001, "g_m2");
    cyc(0, 1, 3'd1, 4'b0000, "g_b3");
    cyc(0, 0, 3'd1, 4'b1000, "g_m3");
    chk("over.miss", miss_pulse, 1'b1);
    chk("over.flag", game_over, 1'b1);
    chk("over.playing", playing, 1'b0);
    chk("over.misses", misses, 4'd3);
    cyc(0, 1, 3'd2, 4'b0000, "over_beat");
    cyc(0, 0, 3'd2, 4'b0100, "over_press");
    chk("over.ignored", {hit_pulse, miss_pulse}, 2'b00);
    cyc(1, 0, 3'd2, 4'b0000, "restart2");
    chk("restart2.score", score_bcd, 16'h0000);
    chk("restart2.playing", playing, 1'b1);
    chk("restart2.over", game_over, 1'b0);

    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, 3'd0, 4'b0000, "h11_beat");
      cyc(0, 0, 3'd0, 4'b0001, "h11_hit");
    end
    chk("h11.score", score_bcd, BONUS ? 16'h0012 : 16'h0011);

    for (int i = 0; i < 12000 && m_score < 9999; i++) begin
      cyc(0, 1, 3'd0, 4'b0000, "sat_beat");
      cyc(0, 0, 3'd0, 4'b0001, "sat_hit");
    end
    chk("sat.reached", score_bcd, 16'h9999);
    cyc(0, 1, 3'd0, 4'b0000, "sat_beat2");
    cyc(0, 0, 3'd0, 4'b0001, "sat_hit2");
    chk("sat.hold", score_bcd, 16'h9999);
    chk("sat.combo", combo, 8'hFF);

    // Randomized play against the model
    cyc(1, 0, 3'd0, 4'b0000, "rand_start");
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] nb;
      nb = btn;
      if ($urandom_range(2) == 0)
        nb = ($urandom_range(3) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(3));
      cyc(($urandom_range(127) == 0), ($urandom_range(3) == 0), 3'($urandom), nb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr_judge.md
Name: ddr_judge

Overview:
- Downstream consumer of the DDR arrow controller's output window.
- Samples the hit-slot arrow on every beat tick and judges debounced direction-button presses against it.
- Produces hit/miss pulses, a 4-digit BCD score for the anode/7-seg driver, a combo count and game-over.
- Sits between the arrow controller, the button debouncers and the score display.

Parameters:
- MAX_MISSES, 3, misses allowed before game over (1..15).
- COMBO_W, 8, combo counter width; saturates at all-ones.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts or restarts a game.
- beat_tick  in  1  single-cycle pulse when the arrow window advances.
- hit_arrow  in  3  arrow code currently in the hit slot; 0 left, 1 down, 2 up, 3 right, 3'b1xx blank.
- btn  in  4  debounced button levels, indexed by arrow code.
- hit_pulse  out  1  one-cycle pulse on a correct press.
- miss_pulse  out  1  one-cycle pulse on a wrong press, a press on blank, or a timeout.
- score_bcd  out  16  four BCD digits, [15:12] most significant.
- combo  out  COMBO_W  consecutive hits since the last miss.
- misses  out  4  misses this game.
- playing  out  1  high in ARMED, WINDOW or WAIT.
- game_over  out  1  high in OVER.

Behaviour:
- Reset, asynchronous and active-low:
  - state IDLE.
  - All outputs 0; btn_q 0; target 3'b100.
- Edge detection:
  - btn_q registers btn every cycle.
  - edge = btn & ~btn_q.
  - Level holds are never judged twice.
- States:
  - IDLE: start -> ARMED. Clears score, combo and misses in the same cycle.
  - ARMED: beat_tick -> WINDOW, latching target <= hit_arrow. Presses are ignored.
  - WINDOW: the first cycle with edge != 0 is judged, then the state goes to WAIT.
    - HIT: exactly one edge bit set, index == target, target non-blank.
    - Anything else is a MISS: multiple edges, wrong button, or a press on blank.
  - WINDOW or WAIT on beat_tick:
    - If WINDOW was never judged and target is non-blank, a timeout MISS is generated.
    - target is then re-latched and the state returns to WINDOW.
    - A blank target with no press generates nothing.
  - WAIT: further edges are ignored until beat_tick.
  - OVER: everything is ignored except start (-> ARMED, with clear).
- Simultaneous press edge and beat_tick in WINDOW:
  - The press is judged against the old target; the timeout check is suppressed.
  - The new target is latched and the state stays WINDOW.
- start in any state, including mid-game, restarts: counters cleared, state ARMED, no pulse generated.
- Latency:
  - Judgment is made in the cycle the edge is visible; hit_pulse/miss_pulse are registered and assert the next cycle.
  - score, combo and misses update in the same cycle as the pulse.
- HIT updates:
  - score +1, BCD with carry across digits, saturating at 9999.
  - combo +1, saturating.
- MISS updates:
  - combo <= 0; misses +1.
  - When misses reaches MAX_MISSES, the state goes to OVER in that cycle; game_over rises with miss_pulse.
- hit_pulse and miss_pulse are never high together.

Optional Feature:
- Macro DDR_JUDGE_COMBO_BONUS_EN.
- Defined: a HIT with pre-increment combo >= 10 adds 2 to the score instead of 1, still saturating at 9999. From 9998 a +2 gives 9999.
- Undefined: every hit adds 1 and combo does not affect the score.

Decomposition:
- Shared package ddr_pkg holds:
  - arrow code constants: ARROW_LEFT, ARROW_DOWN, ARROW_UP, ARROW_RIGHT, ARROW_BLANK = 3'b100.
  - judge state enum: IDLE, ARMED, WINDOW, WAIT, OVER.
  - BCD_MAX = 16'h9999.
- One sub-module, bcd_sat_add4: combinational 4-digit BCD add of 1 or 2 with saturation; reusable by the display path.

Test Plan:
- rst low mid-game -> all outputs 0 immediately, without waiting for clk; after release start + beat_tick (hit_arrow=2) + btn[2] rise -> hit_pulse 1 cycle later, score_bcd 16'h0001, combo 1.
- Target 1, btn[3] rise -> miss_pulse, combo 0, misses 1; a second press in the same beat produces no pulse.
- Target 0, no press, next beat_tick -> timeout miss_pulse. Target blank, no press -> no pulse.
- btn[0] rise coincident with beat_tick (old target 0, new target 3) -> hit judged against the old target, no timeout, WINDOW open for 3.
- Three misses with MAX_MISSES=3 -> game_over with the third miss_pulse; presses and beats ignored; start -> score 0, playing 1.
- Score preloaded to 9999 via hits -> further hit leaves 16'h9999. With DDR_JUDGE_COMBO_BONUS_EN defined, the 11th consecutive hit from 0 -> score 16'h0012.
